// File: rtl/reservation_station_param.sv
// Parametrised Tomasulo reservation station: DEPTH entries, NUM_BC broadcast channels,
// oldest-ready issue, flush, dispatch/broadcast bypass, writes refused while full.

module rs_snoop #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int NUM_BC = 2
) (
  input  logic [TAG_W-1:0]         q,
  input  logic [NUM_BC-1:0]        bcen,
  input  logic [NUM_BC*TAG_W-1:0]  bclabel,
  input  logic [NUM_BC*DATA_W-1:0] bcdata,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);
  // Scan from the highest channel down so the lowest matching channel lands last and wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int c = NUM_BC-1; c >= 0; c--) begin
      if (q != '0 && bcen[c] && bclabel[c*TAG_W +: TAG_W] == q) begin
        hit  = 1'b1;
        data = bcdata[c*DATA_W +: DATA_W];
      end
    end
  end
endmodule

module reservation_station_param #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 5,
  parameter int FUNC_W = 5,
  parameter int NUM_BC = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     EXEable,
  input  logic                     WEN,
  input  logic [OP_W-1:0]          opCode,
  input  logic [FUNC_W-1:0]        func,
  input  logic [TAG_W-1:0]         destTag,
  input  logic [DATA_W-1:0]        dataIn1,
  input  logic [DATA_W-1:0]        dataIn2,
  input  logic [TAG_W-1:0]         label1,
  input  logic [TAG_W-1:0]         label2,
  input  logic [NUM_BC-1:0]        BCEN,
  input  logic [NUM_BC*TAG_W-1:0]  BClabel,
  input  logic [NUM_BC*DATA_W-1:0] BCdata,
  output logic [OP_W-1:0]          opOut,
  output logic [FUNC_W-1:0]        funcOut,
  output logic [DATA_W-1:0]        dataOut1,
  output logic [DATA_W-1:0]        dataOut2,
  output logic [TAG_W-1:0]         labelOut,
  output logic                     OutEn,
  output logic                     isFull,
  output logic [CW-1:0]            count
);
  logic [DEPTH-1:0]             valid;
  logic [DEPTH-1:0][OP_W-1:0]   op;
  logic [DEPTH-1:0][FUNC_W-1:0] fn;
  logic [DEPTH-1:0][TAG_W-1:0]  tag, q1, q2;
  logic [DEPTH-1:0][DATA_W-1:0] v1, v2, cap1, cap2;
  logic [DEPTH-1:0][AW-1:0]     age;
  logic [DEPTH-1:0]             hit1, hit2, rdy;

  logic              issue, alloc, free_found, bhit1, bhit2;
  logic [AW-1:0]     sel, sel_age, free_idx, new_rank;
  logic [DATA_W-1:0] bdata1, bdata2, din1, din2;

  genvar e;
  generate
    for (e = 0; e < DEPTH; e++) begin : g_ent
      rs_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BC(NUM_BC)) u_s1 (
        .q(q1[e]), .bcen(BCEN), .bclabel(BClabel), .bcdata(BCdata), .hit(hit1[e]), .data(cap1[e]));
      rs_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BC(NUM_BC)) u_s2 (
        .q(q2[e]), .bcen(BCEN), .bclabel(BClabel), .bcdata(BCdata), .hit(hit2[e]), .data(cap2[e]));
      // Readiness comes from registered tags only; no broadcast-to-issue path.
      assign rdy[e] = valid[e] && q1[e] == '0 && q2[e] == '0;
    end
  endgenerate

  rs_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BC(NUM_BC)) u_byp1 (
    .q(label1), .bcen(BCEN), .bclabel(BClabel), .bcdata(BCdata), .hit(bhit1), .data(bdata1));
  rs_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_BC(NUM_BC)) u_byp2 (
    .q(label2), .bcen(BCEN), .bclabel(BClabel), .bcdata(BCdata), .hit(bhit2), .data(bdata2));

  assign din1 = bhit1 ? bdata1 : dataIn1;
  assign din2 = bhit2 ? bdata2 : dataIn2;

  assign isFull = (count == CW'(DEPTH));

  always_comb begin
    issue   = 1'b0;
    sel     = '0;
    sel_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i] && (!issue || age[i] < sel_age)) begin
        issue   = 1'b1;
        sel     = AW'(i);
        sel_age = age[i];
      end
    end
    issue = issue && EXEable && !flush;
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = AW'(i);
      end
    end
  end

  assign alloc    = WEN && !isFull && !flush && free_found;
  assign new_rank = AW'(count - CW'(issue));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      count    <= '0;
      OutEn    <= 1'b0;
      opOut    <= '0;
      funcOut  <= '0;
      dataOut1 <= '0;
      dataOut2 <= '0;
      labelOut <= '0;
    end else if (flush) begin
      valid <= '0;
      count <= '0;
      OutEn <= 1'b0;
    end else begin
      count <= count + CW'(alloc) - CW'(issue);
      OutEn <= issue;
      if (issue) begin
        opOut    <= op[sel];
        funcOut  <= fn[sel];
        dataOut1 <= v1[sel];
        dataOut2 <= v2[sel];
        labelOut <= tag[sel];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i]) begin
          if (hit1[i]) begin
            v1[i] <= cap1[i];
            q1[i] <= '0;
          end
          if (hit2[i]) begin
            v2[i] <= cap2[i];
            q2[i] <= '0;
          end
          // Keep ranks dense after the issued entry leaves.
          if (issue && age[i] > sel_age) age[i] <= age[i] - 1'b1;
        end
        if (issue && sel == AW'(i)) valid[i] <= 1'b0;
        if (alloc && free_idx == AW'(i)) begin
          valid[i] <= 1'b1;
          op[i]    <= opCode;
          fn[i]    <= func;
          tag[i]   <= destTag;
          v1[i]    <= din1;
          v2[i]    <= din2;
          q1[i]    <= bhit1 ? '0 : label1;
          q2[i]    <= bhit2 ? '0 : label2;
          age[i]   <= new_rank;
        end
      end
    end
  end
endmodule

// File: tb/tb_reservation_station_param.sv
// Directed vector table plus hand-written flush/reset sequences for reservation_station_param.
module tb_reservation_station_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, EXEable, WEN;
  logic [4:0]  opCode, func, destTag, label1, label2;
  logic [31:0] dataIn1, dataIn2;
  logic [1:0]  BCEN;
  logic [9:0]  BClabel;
  logic [63:0] BCdata;
  logic [4:0]  opOut, funcOut, labelOut;
  logic [31:0] dataOut1, dataOut2;
  logic        OutEn, isFull;
  logic [2:0]  count;

  reservation_station_param #(.DEPTH(4), .DATA_W(32), .TAG_W(5), .OP_W(5), .FUNC_W(5), .NUM_BC(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .EXEable(EXEable), .WEN(WEN),
    .opCode(opCode), .func(func), .destTag(destTag), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .label1(label1), .label2(label2), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
    .opOut(opOut), .funcOut(funcOut), .dataOut1(dataOut1), .dataOut2(dataOut2),
    .labelOut(labelOut), .OutEn(OutEn), .isFull(isFull), .count(count));

  typedef struct {
    logic wen, exe;
    logic [4:0] op, dt, l1, l2;
    logic [31:0] d1, d2;
    logic [1:0] bcen;
    logic [4:0] bl0, bl1;
    logic [31:0] bd0, bd1;
    logic e_en, e_full;
    logic [2:0] e_cnt;
    logic [4:0] e_op, e_lbl;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  vec_t vecs[$];
  int errs = 0;
  int checks = 0;

  function automatic vec_t vin(input int wen, exe, op, dt, l1, d1, l2, d2, bcen, bl0, bd0, bl1, bd1);
    vec_t v;
    v.wen = wen[0]; v.exe = exe[0]; v.op = 5'(op); v.dt = 5'(dt);
    v.l1 = 5'(l1); v.d1 = 32'(d1); v.l2 = 5'(l2); v.d2 = 32'(d2);
    v.bcen = 2'(bcen); v.bl0 = 5'(bl0); v.bd0 = 32'(bd0); v.bl1 = 5'(bl1); v.bd1 = 32'(bd1);
    v.e_en = 1'b0; v.e_full = 1'b0; v.e_cnt = '0; v.e_op = '0; v.e_lbl = '0; v.e_d1 = '0; v.e_d2 = '0;
    return v;
  endfunction

  function automatic vec_t vx(input vec_t v, input int en, cnt, full, op, lbl, d1, d2);
    vec_t r = v;
    r.e_en = en[0]; r.e_cnt = 3'(cnt); r.e_full = full[0];
    r.e_op = 5'(op); r.e_lbl = 5'(lbl); r.e_d1 = 32'(d1); r.e_d2 = 32'(d2);
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; EXEable = 0; WEN = 0; opCode = 0; func = 0; destTag = 0;
    dataIn1 = 0; dataIn2 = 0; label1 = 0; label2 = 0; BCEN = 0; BClabel = 0; BCdata = 0;
  endtask

  task automatic drive(input vec_t v);
    WEN = v.wen; EXEable = v.exe; opCode = v.op; func = v.op; destTag = v.dt;
    label1 = v.l1; dataIn1 = v.d1; label2 = v.l2; dataIn2 = v.d2;
    BCEN = v.bcen; BClabel = {v.bl1, v.bl0}; BCdata = {v.bd1, v.bd0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int op, dt, d1, d2, exe);
    idle();
    WEN = 1; EXEable = exe[0]; opCode = 5'(op); func = 5'(op); destTag = 5'(dt);
    dataIn1 = 32'(d1); dataIn2 = 32'(d2);
  endtask

  initial begin
    //                  wen exe op dt l1 d1      l2 d2  bcen bl0 bd0 bl1 bd1          en cnt full op lbl d1 d2
    vecs.push_back(vx(vin(1,1, 1, 7, 0, 2,      0, 4,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 0, 0, 1, 7, 2, 4));
    vecs.push_back(vx(vin(1,1, 3, 8, 0, 8,      2, 0,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  1, 2, 32,   0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 0, 0, 3, 8, 8, 32));
    vecs.push_back(vx(vin(1,1, 4, 9, 9, 'h1111, 0, 5,  2, 0, 0,    9, 'hABCD),      0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 0, 0, 4, 9, 'hABCD, 5));
    vecs.push_back(vx(vin(1,0, 5, 10, 3, 0,     0, 6,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,0, 0, 0, 0, 0,      0, 0,  3, 3, 'h11, 3, 'h22),        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 0, 0, 5, 10, 'h11, 6));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(vx(vin(1,0, k, k, 0, k,    0, k+16, 0, 0, 0,  0, 0),           0, k, (k == 4), 0, 0, 0, 0));
    vecs.push_back(vx(vin(1,0, 5, 5, 0, 5,      0, 21, 0, 0, 0,    0, 0),           0, 4, 1, 0, 0, 0, 0));
    vecs.push_back(vx(vin(1,1, 6, 6, 0, 6,      0, 22, 0, 0, 0,    0, 0),           1, 3, 0, 1, 1, 1, 17));
    for (int k = 2; k <= 4; k++)
      vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,    0, 0,  0, 0, 0,    0, 0),           1, 4-k, 0, k, k, k, k+16));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(1,1, 2, 11, 5, 0,     0, 1,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(1,1, 6, 12, 0, 20,    0, 21, 0, 0, 0,    0, 0),           0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(1,1, 7, 13, 0, 30,    0, 31, 1, 0, 99,   0, 0),           1, 2, 0, 6, 12, 20, 21));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 1, 0, 7, 13, 30, 31));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  2, 0, 0,    5, 'h55),        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(vx(vin(0,1, 0, 0, 0, 0,      0, 0,  0, 0, 0,    0, 0),           1, 0, 0, 2, 11, 'h55, 1));

    idle();
    rst = 1;
    step();
    step();
    chk("rst_outen", 0, 32'(OutEn), 0);
    chk("rst_op", 0, 32'(opOut), 0);
    chk("rst_d1", 0, dataOut1, 0);
    chk("rst_lbl", 0, 32'(labelOut), 0);
    chk("rst_cnt", 0, 32'(count), 0);
    chk("rst_full", 0, 32'(isFull), 0);
    rst = 0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step();
      chk("outen", i, 32'(OutEn), 32'(vecs[i].e_en));
      chk("count", i, 32'(count), 32'(vecs[i].e_cnt));
      chk("full", i, 32'(isFull), 32'(vecs[i].e_full));
      if (vecs[i].e_en) begin
        chk("op", i, 32'(opOut), 32'(vecs[i].e_op));
        chk("func", i, 32'(funcOut), 32'(vecs[i].e_op));
        chk("lbl", i, 32'(labelOut), 32'(vecs[i].e_lbl));
        chk("d1", i, dataOut1, vecs[i].e_d1);
        chk("d2", i, dataOut2, vecs[i].e_d2);
      end
    end

    // Flush with a concurrent dispatch: everything squashed, nothing issues later.
    for (int k = 1; k <= 3; k++) begin
      disp(k, k, k, k, 0);
      step();
    end
    chk("fl_pre_cnt", 0, 32'(count), 3);
    disp(9, 9, 9, 9, 1);
    flush = 1;
    step();
    chk("fl_outen", 0, 32'(OutEn), 0);
    chk("fl_cnt", 0, 32'(count), 0);
    idle();
    EXEable = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("fl_post_outen", k, 32'(OutEn), 0);
      chk("fl_post_cnt", k, 32'(count), 0);
    end

    // Reset while a broadcast and dispatch are in flight.
    disp(9, 15, 'h77, 'h88, 1);
    step();
    idle();
    EXEable = 1;
    step();
    chk("pr_outen", 0, 32'(OutEn), 1);
    chk("pr_op", 0, 32'(opOut), 9);
    disp(3, 3, 3, 3, 1);
    BCEN = 2'b11;
    BClabel = {5'd3, 5'd3};
    BCdata = {32'h5, 32'h6};
    rst = 1;
    step();
    chk("rr_outen", 0, 32'(OutEn), 0);
    chk("rr_op", 0, 32'(opOut), 0);
    chk("rr_func", 0, 32'(funcOut), 0);
    chk("rr_d1", 0, dataOut1, 0);
    chk("rr_d2", 0, dataOut2, 0);
    chk("rr_lbl", 0, 32'(labelOut), 0);
    chk("rr_cnt", 0, 32'(count), 0);
    rst = 0;
    idle();
    EXEable = 1;
    step();
    chk("rr_post_outen", 0, 32'(OutEn), 0);
    chk("rr_post_cnt", 0, 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/reservation_station_param.md
Name: reservation_station_param

Overview:
- Parametrised Tomasulo reservation station; next generation of the single-bus ALU station.
- Holds up to DEPTH dispatched instructions and snoops NUM_BC common-data-bus broadcast channels for missing operands.
- Issues the oldest fully-ready entry to its functional unit when EXEable is high.
- Sits between the dispatch/rename stage and one functional unit. Adds three things: a flush input, a same-cycle dispatch/broadcast bypass, and refusal of writes while full.

Parameters:
- DEPTH, 4, number of entries (2..16).
- DATA_W, 32, operand width.
- TAG_W, 5, tag width; tag 0 is reserved and means "operand valid".
- OP_W, 5, opcode width.
- FUNC_W, 5, func field width.
- NUM_BC, 2, number of broadcast channels.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high. The clock port is named clk and the reset port is named rst.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous squash of all entries.
- EXEable  in  1  functional unit can accept an instruction this cycle.
- WEN  in  1  dispatch request.
- opCode  in  OP_W  dispatched opcode.
- func  in  FUNC_W  dispatched func field.
- destTag  in  TAG_W  tag this instruction will broadcast.
- dataIn1 / dataIn2  in  DATA_W  operand values (used when the matching label is 0).
- label1 / label2  in  TAG_W  producer tags; 0 means the data is valid.
- BCEN  in  NUM_BC  per-channel broadcast valid.
- BClabel  in  NUM_BC*TAG_W  packed broadcast tags; channel i is at bits [i*TAG_W +: TAG_W].
- BCdata  in  NUM_BC*DATA_W  packed broadcast data, same packing.
- opOut  out  OP_W  issued opcode.
- funcOut  out  FUNC_W  issued func field.
- dataOut1 / dataOut2  out  DATA_W  issued operands.
- labelOut  out  TAG_W  issued destTag.
- OutEn  out  1  issue valid, one-cycle pulse.
- isFull  out  1  combinational; count == DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Entry state: valid, op, func, tag, v1, q1, v2, q2, age rank.
- Operand ready condition: q == 0.
- Reset: all valid bits cleared; all registered outputs (opOut, funcOut, dataOut1, dataOut2, labelOut, OutEn) set to 0; count = 0.
  - Reset has priority over flush, dispatch and broadcast.
- Flush: at the edge, clears all valid bits and forces OutEn = 0.
  - Dispatch in the same cycle is discarded.
  - count = 0 next cycle.
- Dispatch:
  - WEN && !isFull: allocate the lowest-index free entry at the edge.
  - WEN && isFull: ignored; no state change; no error flag.
  - isFull is evaluated before same-cycle issue, so a full station refuses a write even in a cycle where it issues.
- Dispatch bypass: if labelN != 0 and some channel i has BCEN[i] && BClabel[i] == labelN in the same cycle, the entry stores BCdata[i] with qN = 0.
- Broadcast capture: for every valid entry and each operand with q != 0:
  - A match on channel i writes v <= BCdata[i], q <= 0.
  - If several channels match the same tag, the lowest channel index wins.
  - Broadcasts with tag 0 are ignored.
- Issue readiness: evaluated on registered state only. An operand captured at edge N makes its entry issuable at edge N+1 at the earliest; there is no combinational broadcast-to-issue path.
- Issue:
  - At an edge where EXEable = 1 and at least one valid entry has q1 = q2 = 0, select the entry with the smallest age rank (oldest dispatch).
  - Register its fields into the outputs, set OutEn = 1, and clear that entry's valid bit.
  - Otherwise OutEn = 0 and the data outputs hold their previous values.
  - Latency: dispatch with both operands ready at edge N → earliest OutEn at edge N+1.
- Age rank:
  - A new entry gets rank = count after this cycle's issue removal.
  - When an entry of rank r issues, every entry with rank > r decrements by 1.
  - Ranks stay a dense permutation 0..count-1.
- Simultaneous issue and dispatch (not full): both occur; count is unchanged.
- Freed slot: an entry freed by issue is allocatable from the next edge.
- count: updates each edge as count + alloc - issue.

Test Plan:
- Reset then dispatch op=1, d1=2, d2=4, labels 0/0, destTag=7, EXEable=1 → next edge OutEn=1, opOut=1, dataOut1=2, dataOut2=4, labelOut=7, count returns to 0.
- Dispatch op=3, label2=2, d1=8, EXEable=1; two cycles later BCEN=01, BClabel ch0=2, BCdata=32 → OutEn one edge after the broadcast, dataOut1=8, dataOut2=32, never earlier.
- Dispatch label1=9 in the same cycle as a ch1 broadcast of tag 9 with data 0xABCD → entry stores 0xABCD and issues the next edge with dataOut1=0xABCD.
- DEPTH=4, EXEable=0, five dispatches → isFull=1 after the 4th, the 5th is ignored, count=4. Then EXEable=1 → four issues in dispatch order (destTags 1,2,3,4), then OutEn=0.
- Dispatch A (waiting on tag 5), then B and C both ready, EXEable=1 → B then C issue. A issues one edge after the tag-5 broadcast.
- Fill 3 entries, assert flush together with WEN → count=0, OutEn=0 next cycle, nothing issues afterwards. Assert rst mid-broadcast → all outputs 0.
